// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding,
// transfer direction constants and the turnaround counter width.
package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TA   = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Turnaround counter width; TA_CYC is limited to 0..7.
    localparam int TA_W = 3;

endpackage

// File: rtl/tristate_bus_arbiter_rr_arbiter.sv
// Round-robin priority pick: the first set request bit at or above rr_ptr,
// wrapping around. Purely combinational; returns one-hot and index forms.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int p;
        p         = 0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(rr_ptr) + k;
            if (p >= N) begin
                p = p - N;
            end
            if (req[p]) begin
                grant_idx = IDX_W'(p);
                valid     = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign grant[gi] = valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for N single-beat requesters sharing one half-duplex
// tristate bus. Direction changes insert TA_CYC turnaround cycles with the
// bus released. Optional macro BUS_PARK_EN keeps the bus driven with the
// last written value while idle after a write.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 2,
    parameter int TA_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] wr,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0] gnt,
    output logic [W-1:0] rdata,
    output logic         rvalid,
    inout  wire  [W-1:0] bus,
    output logic         bus_oe,
    output logic         busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef BUS_PARK_EN
    localparam logic PARK_EN = 1'b1;
`else
    localparam logic PARK_EN = 1'b0;
`endif

    state_t            state_reg;
    logic [TA_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]  win_idx_reg;
    logic              win_dir_reg;
    logic              last_dir_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [N-1:0]      gnt_reg;
    logic              bus_oe_reg;
    logic [W-1:0]      rdata_reg;
    logic              rvalid_reg;

    logic [N-1:0]      pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [W-1:0]      wdata_sel;
    logic [W-1:0]      drive_data;
    logic [IDX_W-1:0]  rr_ptr_next;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // Write data of the latched winner, taken live from the requester.
    assign wdata_sel   = wdata[win_idx_reg*W +: W];
    assign rr_ptr_next = (win_idx_reg == IDX_W'(N - 1)) ? '0 : win_idx_reg + IDX_W'(1);

`ifdef BUS_PARK_EN
    logic [W-1:0] park_reg;
    assign drive_data = (state_reg == ST_XFER) ? wdata_sel : park_reg;
`else
    assign drive_data = wdata_sel;
`endif

    // Pad-side tristate driver.
    assign bus    = bus_oe_reg ? drive_data : {W{1'bz}};
    assign bus_oe = bus_oe_reg;
    assign gnt    = gnt_reg;
    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign busy   = (state_reg != ST_IDLE);

    // Arbitration FSM with registered grant, drive-enable and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            win_idx_reg  <= '0;
            win_dir_reg  <= DIR_READ;
            last_dir_reg <= DIR_READ;
            rr_ptr_reg   <= '0;
            gnt_reg      <= '0;
            bus_oe_reg   <= 1'b0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
`ifdef BUS_PARK_EN
            park_reg     <= '0;
`endif
        end else begin
            rvalid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    gnt_reg <= '0;
                    if (pick_valid) begin
                        win_idx_reg <= pick_idx;
                        win_dir_reg <= wr[pick_idx];
                        if ((wr[pick_idx] != last_dir_reg) && (TA_CYC > 0)) begin
                            state_reg  <= ST_TA;
                            cnt_reg    <= TA_W'(TA_CYC - 1);
                            bus_oe_reg <= 1'b0;
                        end else begin
                            state_reg  <= ST_XFER;
                            gnt_reg    <= pick_onehot;
                            bus_oe_reg <= wr[pick_idx];
                        end
                    end else begin
                        bus_oe_reg <= PARK_EN && (last_dir_reg == DIR_WRITE);
                    end
                end
                ST_TA: begin
                    if (!req[win_idx_reg]) begin
                        // Requester withdrew: no grant, history untouched.
                        state_reg  <= ST_IDLE;
                        bus_oe_reg <= PARK_EN && (last_dir_reg == DIR_WRITE);
                    end else if (cnt_reg == '0) begin
                        state_reg  <= ST_XFER;
                        gnt_reg    <= {{(N-1){1'b0}}, 1'b1} << win_idx_reg;
                        bus_oe_reg <= win_dir_reg;
                    end else begin
                        cnt_reg <= cnt_reg - TA_W'(1);
                    end
                end
                ST_XFER: begin
                    state_reg    <= ST_IDLE;
                    gnt_reg      <= '0;
                    last_dir_reg <= win_dir_reg;
                    rr_ptr_reg   <= rr_ptr_next;
                    bus_oe_reg   <= PARK_EN && (win_dir_reg == DIR_WRITE);
                    if (win_dir_reg == DIR_READ) begin
                        rdata_reg  <= bus;
                        rvalid_reg <= 1'b1;
                    end
`ifdef BUS_PARK_EN
                    else begin
                        park_reg <= wdata_sel;
                    end
`endif
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    gnt_reg    <= '0;
                    bus_oe_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter at N=2, W=2, TA_CYC=1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] wr;
    logic [3:0] wdata;
    logic [1:0] gnt;
    logic [1:0] rdata;
    logic       rvalid;
    wire  [1:0] bus;
    logic       bus_oe;
    logic       busy;

    logic       ext_en;
    logic [1:0] ext_drv;

    int checks   = 0;
    int failures = 0;

    assign bus = ext_en ? ext_drv : 2'bzz;

    tristate_bus_arbiter #(
        .N      (2),
        .W      (2),
        .TA_CYC (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .bus    (bus),
        .bus_oe (bus_oe),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_b;

        rst = 1'b1; req = 2'b00; wr = 2'b00; wdata = 4'b0000;
        ext_en = 1'b0; ext_drv = 2'b00;
        step();
        step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bus_oe", bus_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 2'b00);
        rst = 1'b0;
        step();

        // First write after reset: direction READ->WRITE forces one TA cycle.
        req = 2'b01; wr = 2'b01; wdata = 4'b0010;
        step();
        $display("txn write1 ta: busy=%0b bus_oe=%0b gnt=%b", busy, bus_oe, gnt);
        chk("w1_ta_busy", busy, 1'b1);
        chk("w1_ta_bus_oe", bus_oe, 1'b0);
        chk("w1_ta_gnt", gnt, 2'b00);
        step();
        $display("txn write1 xfer: gnt=%b bus_oe=%0b bus=%b", gnt, bus_oe, bus);
        chk("w1_gnt", gnt, 2'b01);
        chk("w1_bus_oe", bus_oe, 1'b1);
        chk("w1_bus", bus, 2'b10);
        req = 2'b00;
        step();
        chk("w1_idle_gnt", gnt, 2'b00);
        chk("w1_idle_busy", busy, 1'b0);
        chk("w1_idle_bus_oe", bus_oe, 1'b0);

        // Second write, same direction: XFER directly, no TA.
        req = 2'b01; wr = 2'b01; wdata = 4'b0001;
        step();
        $display("txn write2 xfer: gnt=%b bus_oe=%0b bus=%b", gnt, bus_oe, bus);
        chk("w2_gnt", gnt, 2'b01);
        chk("w2_bus_oe", bus_oe, 1'b1);
        chk("w2_bus", bus, 2'b01);
        req = 2'b00;
        step();

        // Read after write from requester 1; external driver supplies 2'b11.
        req = 2'b10; wr = 2'b00; ext_en = 1'b1; ext_drv = 2'b11;
        step();
        $display("txn read ta: busy=%0b bus_oe=%0b gnt=%b", busy, bus_oe, gnt);
        chk("rd_ta_busy", busy, 1'b1);
        chk("rd_ta_bus_oe", bus_oe, 1'b0);
        chk("rd_ta_gnt", gnt, 2'b00);
        step();
        $display("txn read xfer: gnt=%b bus_oe=%0b", gnt, bus_oe);
        chk("rd_gnt", gnt, 2'b10);
        chk("rd_xfer_bus_oe", bus_oe, 1'b0);
        chk("rd_xfer_rvalid", rvalid, 1'b0);
        req = 2'b00;
        step();
        $display("txn read data: rvalid=%0b rdata=%b", rvalid, rdata);
        chk("rd_rvalid", rvalid, 1'b1);
        chk("rd_rdata", rdata, 2'b11);
        chk("rd_idle_busy", busy, 1'b0);
        ext_en = 1'b0;
        step();
        chk("rd_rvalid_pulse", rvalid, 1'b0);

        // Contention: both write continuously; rr_ptr=0, last_dir=READ -> one TA.
        req = 2'b11; wr = 2'b11; wdata = 4'b1101;
        step();
        chk("ct_ta_gnt", gnt, 2'b00);
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_b = (k % 2 == 0) ? 2'b01 : 2'b11;
            step();
            $display("txn contention %0d: gnt=%b bus=%b", k, gnt, bus);
            chk("ct_gnt", gnt, exp_g);
            chk("ct_bus", bus, exp_b);
            step();
            chk("ct_gap_gnt", gnt, 2'b00);
        end
        req = 2'b00;
        step();

        // Abort: read from requester 0 after writes needs TA; drop req during TA.
        req = 2'b01; wr = 2'b00;
        step();
        chk("ab_ta_busy", busy, 1'b1);
        chk("ab_ta_gnt", gnt, 2'b00);
        req = 2'b00;
        step();
        $display("txn abort: gnt=%0b busy=%0b rvalid=%0b", gnt, busy, rvalid);
        chk("ab_gnt", gnt, 2'b00);
        chk("ab_busy", busy, 1'b0);
        chk("ab_rvalid", rvalid, 1'b0);
        // rr_ptr still 0 and last_dir still WRITE: immediate grant to requester 0.
        req = 2'b11; wr = 2'b11; wdata = 4'b1110;
        step();
        $display("txn after abort: gnt=%b bus=%b", gnt, bus);
        chk("ab_next_gnt", gnt, 2'b01);
        chk("ab_next_bus", bus, 2'b10);
        req = 2'b00;
        step();

        // Reset during a write XFER (rr_ptr=1, only requester 0 asks).
        req = 2'b01; wr = 2'b01; wdata = 4'b0011;
        step();
        chk("mr_gnt", gnt, 2'b01);
        chk("mr_bus_oe", bus_oe, 1'b1);
        rst = 1'b1; req = 2'b00;
        step();
        $display("txn reset mid-xfer: gnt=%b bus_oe=%0b busy=%0b", gnt, bus_oe, busy);
        chk("mr_after_bus_oe", bus_oe, 1'b0);
        chk("mr_after_gnt", gnt, 2'b00);
        chk("mr_after_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        // After reset last_dir is READ again: a write needs TA.
        req = 2'b10; wr = 2'b10; wdata = 4'b0100;
        step();
        chk("pr_ta_gnt", gnt, 2'b00);
        step();
        chk("pr_gnt", gnt, 2'b10);
        chk("pr_bus", bus, 2'b01);
        req = 2'b00;
        step();

`ifdef BUS_PARK_EN
        // Idle after a write of 2'b01: bus stays parked.
        chk("pk_bus_oe", bus_oe, 1'b1);
        chk("pk_bus", bus, 2'b01);
        req = 2'b01; wr = 2'b00;
        step();
        chk("pk_ta_bus_oe", bus_oe, 1'b0);
        ext_en = 1'b1; ext_drv = 2'b10;
        step();
        chk("pk_rd_gnt", gnt, 2'b01);
        chk("pk_rd_bus_oe", bus_oe, 1'b0);
        req = 2'b00;
        step();
        chk("pk_rd_rdata", rdata, 2'b10);
        ext_en = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
